// File: rtl/ysyx_23060180_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060180_mem_arbiter_if
// Bundles the fetch request/response channel, the load/store request/response
// channel and the shared memory port of the ysyx_23060180 memory arbiter.
//
// Signal summary:
//   ifu_req_valid/ifu_req_ready/ifu_addr        fetch request handshake
//   ifu_rsp_valid/ifu_rdata                     fetch response pulse + word
//   lsu_req_valid/lsu_req_ready/lsu_wen/
//   lsu_addr/lsu_wdata/lsu_wbit_en              load/store request handshake
//   lsu_rsp_valid/lsu_rdata                     load/store response pulse + word
//   mem_rd/mem_wr/mem_raddr/mem_wdata/
//   mem_wbit_en/mem_rdata                       synchronous memory port
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding core + memory model that drives the arbiter
// ---------------------------------------------------------------------------
interface ysyx_23060180_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rdata;

  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic          lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wbit_en;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rdata;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wbit_en;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wbit_en,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en,
    input  mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wbit_en,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en,
    output mem_rdata
  );
endinterface

// File: rtl/ysyx_23060180_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060180_mem_arbiter
// Shares one synchronous memory port between instruction fetch (read only)
// and the load/store unit. Requests are accepted with valid/ready, arbitrated
// round-robin on ties, issued one at a time, and answered with a one-cycle
// response pulse on the requesting side.
//
// Ports:
//   clk      - clock
//   rstn_in  - asynchronous active-low reset
//   io_bus   - ysyx_23060180_mem_arbiter_if.slave: fetch channel, load/store
//              channel and memory port (see the interface file)
//
// Parameters:
//   AW, DW   - address / data width (must match the interface)
//   RD_LAT   - cycles from mem_rd high to mem_rdata valid, 1..4
// ---------------------------------------------------------------------------
module ysyx_23060180_mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rstn_in,
  ysyx_23060180_mem_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // r_last_grant / r_src encoding: 0 = IFU, 1 = LSU
  logic          r_last_grant;
  logic          r_src;
  logic          r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wbit_en;
  logic [2:0]    r_cnt;
  logic          r_ifu_rsp_valid;
  logic          r_lsu_rsp_valid;
  logic [DW-1:0] r_ifu_rdata;
  logic [DW-1:0] r_lsu_rdata;

  logic          w_grant_ifu;
  logic          w_grant_lsu;
  logic          w_idle;
  logic          w_hs;
  logic          w_issue;
  logic          w_capture;

  // On a tie the side that did not win last time gets the port; the reset
  // value of r_last_grant (IFU) therefore lets the LSU win the first tie.
  always_comb begin
    w_grant_lsu = io_bus.lsu_req_valid && (!io_bus.ifu_req_valid || !r_last_grant);
    w_grant_ifu = io_bus.ifu_req_valid && !w_grant_lsu;
  end

  assign w_idle    = (r_state == S_IDLE);
  assign w_hs      = w_idle && (w_grant_lsu || w_grant_ifu);
  assign w_issue   = (r_state == S_ISSUE);
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 3'd1);

  // State register
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_wen ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch at the handshake; IFU requests are always reads.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_last_grant <= 1'b0;
      r_src        <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wbit_en    <= '0;
    end else if (w_hs) begin
      r_last_grant <= w_grant_lsu;
      r_src        <= w_grant_lsu;
      r_wen        <= w_grant_lsu && io_bus.lsu_wen;
      r_addr       <= w_grant_lsu ? io_bus.lsu_addr    : io_bus.ifu_addr;
      r_wdata      <= w_grant_lsu ? io_bus.lsu_wdata   : '0;
      r_wbit_en    <= w_grant_lsu ? io_bus.lsu_wbit_en : 4'd0;
    end
  end

  // Read latency counter: loaded while issuing, reaches 1 in the cycle the
  // memory presents its data.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= 3'(RD_LAT);
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Response registers: each side's data holds until its next response.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_ifu_rdata     <= '0;
      r_lsu_rdata     <= '0;
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        if (r_src) r_lsu_rdata <= io_bus.mem_rdata;
        else       r_ifu_rdata <= io_bus.mem_rdata;
      end
      r_ifu_rsp_valid <= (w_state_nxt == S_RESP) && !r_src;
      r_lsu_rsp_valid <= (w_state_nxt == S_RESP) &&  r_src;
    end
  end

  assign io_bus.ifu_req_ready = w_idle && w_grant_ifu;
  assign io_bus.lsu_req_ready = w_idle && w_grant_lsu;
  assign io_bus.ifu_rsp_valid = r_ifu_rsp_valid;
  assign io_bus.lsu_rsp_valid = r_lsu_rsp_valid;
  assign io_bus.ifu_rdata     = r_ifu_rdata;
  assign io_bus.lsu_rdata     = r_lsu_rdata;

  // Strobes and write payload are only driven during the issue cycle; the
  // address keeps the last latched value so it stays quiet between accesses.
  assign io_bus.mem_rd      = w_issue && !r_wen;
  assign io_bus.mem_wr      = w_issue &&  r_wen;
  assign io_bus.mem_raddr   = r_addr;
  assign io_bus.mem_wdata   = w_issue ? r_wdata   : '0;
  assign io_bus.mem_wbit_en = w_issue ? r_wbit_en : 4'd0;

endmodule
